// File: rtl/adder_seq_ctrl_pkg.sv
// rtl/adder_seq_ctrl_pkg.sv - shared encodings and helpers for the multi-byte add sequencer
package adder_seq_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_RUN   = RUN,
        S_FLUSH = FLUSH
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_beh_dff.sv
// rtl/adder_beh_dff.sv - registered 8-bit adder, one-clock latency, no reset
module adder_beh_dff
    import adder_seq_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic [SLICE_W-1:0] din1,
    input  logic [SLICE_W-1:0] din2,
    input  logic               cin,
    output logic [SLICE_W-1:0] dout,
    output logic               cout
);

    always_ff @(posedge clk) begin
        {cout, dout} <= {1'b0, din1} + {1'b0, din2} + {{SLICE_W{1'b0}}, cin};
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - wide add sequencer issuing LSB-first byte slices to the shared registered adder
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = SLICE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int               IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_prev;
    logic [W-1:0]       a_reg, b_reg, res_reg, res_done;
    logic               cin_reg;
    logic [SLICE_W-1:0] din1, din2, add_dout;
    logic               add_cin, add_cout;

    adder_beh_dff u_adder (
        .clk  (clk),
        .din1 (din1),
        .din2 (din2),
        .cin  (add_cin),
        .dout (add_dout),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        din1      = '0;
        din2      = '0;
        add_cin   = 1'b0;
        idx_prev  = idx - IDX_W'(1);
        res_done  = res_reg;
        res_done[(NBYTES-1)*SLICE_W +: SLICE_W] = add_dout;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                din1 = a_reg[int'(idx)*SLICE_W +: SLICE_W];
                din2 = b_reg[int'(idx)*SLICE_W +: SLICE_W];
                // slice 0 takes the host carry; later slices chain the adder's registered carry
                add_cin = (idx == '0) ? cin_reg : add_cout;
                if (idx == LAST_IDX) state_nxt = S_FLUSH;
            end
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            cin_reg <= 1'b0;
            res_reg <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        cin_reg <= cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    // adder output lags one cycle, so this edge captures the previous slice
                    if (idx != '0) res_reg[int'(idx_prev)*SLICE_W +: SLICE_W] <= add_dout;
                    if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
                end
                S_FLUSH: begin
                    res_reg <= res_done;
                    sum     <= res_done;
                    cout    <= add_cout;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl with directed vectors
module tb_adder_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    adder_seq_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
                end else begin
                    e = q.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_cycles", 64'(busy_run), 64'(NB + 1));
                end
                busy_run = 0;
                if (prev_done) begin
                    checks++;
                    failures++;
                    $display("FAIL done_width: got done high two cycles expected one-cycle pulse");
                end
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic [W-1:0] es, input logic ec, input bit push);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        if (push) q.push_back('{es, ec, cyc + 6});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done: got no done expected done within 30 cycles");
        end
    endtask

    initial begin
        #3 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b1);
        wait_done();
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        wait_done();
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        wait_done();
        issue(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b1);
        wait_done();
        issue(32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
        wait_done();

        // start re-pulsed mid-operation must be ignored
        issue(32'h0101_0101, 32'h0202_0202, 1'b0, 32'h0303_0303, 1'b0, 1'b1);
        a     = 32'h5555_5555;
        b     = 32'h5555_5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("sum_hold", 64'(sum), 64'(32'h0000_0100));
        check("busy_mid", 64'(busy), 64'(1));
        wait_done();
        // start during the done cycle is accepted with no extra bubble
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b1);
        wait_done();

        // reset mid-operation aborts without a done pulse
        issue(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b1);
        wait_done();

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'(0));
        check("final_sum_hold", 64'(sum), 64'(32'h0000_0030));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-byte add sequencer built around the team's registered 8-bit adder (adder_beh_dff, one-clock output latency, no reset). It takes one wide operand pair and issues one byte-slice per cycle to the adder, LSB first. The registered carry-out of each slice feeds the next slice's carry-in. It presents the wide sum with a start/busy/done handshake. It sits between a host and the shared adder so wide adds reuse the existing datapath.

Parameters:
NBYTES, 4, number of 8-bit slices; operand width W = 8*NBYTES; legal range 1..16.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request pulse; sampled only in IDLE.
a  input  W  operand A; sampled on the start-accept edge.
b  input  W  operand B; sampled on the start-accept edge.
cin  input  1  carry-in for slice 0; sampled on the start-accept edge.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when sum/cout become valid.
sum  output  W  result; holds its value until the next done.
cout  output  1  carry-out of the top slice; holds its value until the next done.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. On rst: state=IDLE, idx=0, busy=0, done=0, sum=0, cout=0, and the operand/result shadow registers are cleared.
- The adder's internal flops have no reset, so adder outputs are undefined until the first issue. The controller never consumes adder output outside RUN/FLUSH.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - done is driven 0 on every edge except the FLUSH->IDLE edge.
  - If start=1: latch a, b, cin; idx<=0; busy<=1; go to RUN.
- RUN, with idx=i:
  - Drive din1=a_reg[8i+7:8i] and din2=b_reg[8i+7:8i].
  - Adder carry-in = cin_reg when i=0, else the adder's registered cout (carry of slice i-1).
  - If i>0: res_reg[8(i-1)+7:8(i-1)] <= adder dout.
  - If i=NBYTES-1: go to FLUSH. Otherwise idx<=i+1.
- FLUSH:
  - res top byte <= adder dout.
  - sum <= completed result; cout <= adder cout.
  - done<=1, busy<=0; go to IDLE.
- Latency: start accepted at edge E0; done rises at edge E(NBYTES+1) (E5 for NBYTES=4). busy is high for exactly NBYTES+1 cycles. Throughput is one op per NBYTES+2 cycles.
- start while busy: ignored; no queueing.
- start during the done cycle: accepted (state is already IDLE), so back-to-back ops have no bubble beyond the done cycle.
- NBYTES=1: RUN is entered once and goes straight to FLUSH.
- Outside RUN the adder inputs are held at 0 and cin at 0.
- sum and cout change only at done edges and at reset.
- Reset mid-operation aborts: no done pulse, outputs return to reset values, the next start behaves normally.
- Width rule: sum = (a + b + cin) mod 2^W; cout = bit W of the full sum.

Decomposition:
- Shared header: state encoding localparams (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2) and SLICE_W=8.
- One sub-module: adder_beh_dff, instantiated once, with clk connected to clk.
- idx counter width is clog2(NBYTES), minimum 1 bit.

Test Plan:
1. Assert rst mid-cycle, asynchronously -> busy=0, done=0, sum=0x00000000, cout=0 immediately, before any clk edge.
2. a=0x00000001, b=0x00000002, cin=0 -> busy for 5 cycles, done one cycle at E5, sum=0x00000003, cout=0.
3. Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1. Also a=0x80000000, b=0x80000000 -> sum=0x00000000, cout=1.
4. Carry-in path: a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0. Also a=0x000000FF, b=0, cin=1 -> sum=0x00000100.
5. Handshake: start re-pulsed at E2 with a=b=0x55555555 -> ignored, first result unchanged. Start held during the done cycle with a=0x0000FFFF, b=0x00000001 -> accepted, next done 0x00010000, six cycles after the first done.
6. rst asserted at E2 of an op, released, then a=0x00000010, b=0x00000020 -> no done during abort, then sum=0x00000030, cout=0.
